// File: rtl/bpu_pkg.sv
// Shared branch-predictor definitions: predictor mode encodings and
// saturating-counter helpers used by every counter table.
package bpu_pkg;

    localparam int unsigned MODE_TOURNAMENT = 0;
    localparam int unsigned MODE_BIMODAL    = 1;
    localparam int unsigned MODE_GSHARE     = 2;

    // Weakly-not-taken value: one below the taken threshold.
    function automatic int unsigned weak_nt(input int unsigned cnt_w);
        return (32'd1 << (cnt_w - 32'd1)) - 32'd1;
    endfunction

    function automatic int unsigned sat_inc(input int unsigned cnt, input int unsigned cnt_w);
        int unsigned max_v;
        max_v = (32'd1 << cnt_w) - 32'd1;
        return (cnt >= max_v) ? max_v : cnt + 32'd1;
    endfunction

    function automatic int unsigned sat_dec(input int unsigned cnt);
        return (cnt == 32'd0) ? 32'd0 : cnt - 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter_table.sv
// Table of saturating counters with one combinational read port and one
// read-modify-write update port; reads see the pre-update value.
module sat_counter_table
    import bpu_pkg::*;
#(
    parameter int unsigned IDX_W = 6,
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [CNT_W-1:0] rd_cnt_c_o,
    input  logic             upd_en_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_inc_i,
    output logic [CNT_W-1:0] upd_cnt_c_o
);

    localparam int unsigned      ENTRIES = 32'd1 << IDX_W;
    localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(weak_nt(CNT_W));

    logic [CNT_W-1:0] cnt_q [ENTRIES];
    logic [CNT_W-1:0] upd_val_d;

    assign rd_cnt_c_o  = cnt_q[rd_idx_i];
    assign upd_cnt_c_o = cnt_q[upd_idx_i];

    always_comb begin
        upd_val_d = upd_cnt_c_o;
        if (upd_inc_i) begin
            upd_val_d = CNT_W'(sat_inc(32'(upd_cnt_c_o), CNT_W));
        end else begin
            upd_val_d = CNT_W'(sat_dec(32'(upd_cnt_c_o)));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= CNT_RST;
            end
        end else if (upd_en_i) begin
            cnt_q[upd_idx_i] <= upd_val_d;
        end
    end

endmodule

// File: rtl/tournament_predictor.sv
// Tournament branch predictor: bimodal and gshare tables arbitrated by a
// per-PC chooser, with a speculatively shifted, repairable global history.
module tournament_predictor
    import bpu_pkg::*;
#(
    parameter int unsigned PC_W  = 9,
    parameter int unsigned IDX_W = 6,
    parameter int unsigned GHR_W = 6,
    parameter int unsigned CNT_W = 2,
    parameter int unsigned MODE  = 0
) (
    input  logic             in_Clk,
    input  logic             in_Rst,
    input  logic             in_pred_valid,
    input  logic [PC_W-1:0]  in_pred_PC,
    output logic             out_pred_valid,
    output logic             out_prediction,
    output logic [GHR_W-1:0] out_pred_ghr,
    input  logic             in_upd_valid,
    input  logic [PC_W-1:0]  in_upd_PC,
    input  logic [GHR_W-1:0] in_upd_ghr,
    input  logic             in_upd_taken,
    input  logic             in_upd_mispredict
);

    logic [GHR_W-1:0] ghr_q, ghr_d;
    logic [GHR_W-1:0] pghr_q, pghr_d;
    logic             valid_q, valid_d;
    logic             pred_q, pred_d;

    logic [IDX_W-1:0] pred_bidx, pred_gidx, upd_bidx, upd_gidx;
    logic [CNT_W-1:0] bim_rd, gsh_rd, cho_rd;
    logic [CNT_W-1:0] bim_upd, gsh_upd, cho_upd;
    logic             lookup_pred;
    logic             bim_upd_p, gsh_upd_p;
    logic             cho_upd_en, cho_inc;
    logic             unused_c;

    assign pred_bidx = in_pred_PC[IDX_W-1:0];
    assign pred_gidx = pred_bidx ^ IDX_W'(ghr_q);
    assign upd_bidx  = in_upd_PC[IDX_W-1:0];
    assign upd_gidx  = upd_bidx ^ IDX_W'(in_upd_ghr);

    // Upper PC bits and the chooser's update-side read are not needed.
    assign unused_c = ^{in_pred_PC, in_upd_PC, cho_upd};

    assign bim_upd_p  = bim_upd[CNT_W-1];
    assign gsh_upd_p  = gsh_upd[CNT_W-1];
    assign cho_upd_en = in_upd_valid && (MODE == MODE_TOURNAMENT) && (bim_upd_p != gsh_upd_p);
    assign cho_inc    = (gsh_upd_p == in_upd_taken);

    sat_counter_table #(.IDX_W(IDX_W), .CNT_W(CNT_W)) u_bim (
        .clk_i      (in_Clk),
        .rst_i      (in_Rst),
        .rd_idx_i   (pred_bidx),
        .rd_cnt_c_o (bim_rd),
        .upd_en_i   (in_upd_valid),
        .upd_idx_i  (upd_bidx),
        .upd_inc_i  (in_upd_taken),
        .upd_cnt_c_o(bim_upd)
    );

    sat_counter_table #(.IDX_W(IDX_W), .CNT_W(CNT_W)) u_gsh (
        .clk_i      (in_Clk),
        .rst_i      (in_Rst),
        .rd_idx_i   (pred_gidx),
        .rd_cnt_c_o (gsh_rd),
        .upd_en_i   (in_upd_valid),
        .upd_idx_i  (upd_gidx),
        .upd_inc_i  (in_upd_taken),
        .upd_cnt_c_o(gsh_upd)
    );

    sat_counter_table #(.IDX_W(IDX_W), .CNT_W(CNT_W)) u_cho (
        .clk_i      (in_Clk),
        .rst_i      (in_Rst),
        .rd_idx_i   (pred_bidx),
        .rd_cnt_c_o (cho_rd),
        .upd_en_i   (cho_upd_en),
        .upd_idx_i  (upd_bidx),
        .upd_inc_i  (cho_inc),
        .upd_cnt_c_o(cho_upd)
    );

    always_comb begin
        lookup_pred = bim_rd[CNT_W-1];
        case (MODE)
            MODE_BIMODAL: lookup_pred = bim_rd[CNT_W-1];
            MODE_GSHARE:  lookup_pred = gsh_rd[CNT_W-1];
            default:      lookup_pred = cho_rd[CNT_W-1] ? gsh_rd[CNT_W-1] : bim_rd[CNT_W-1];
        endcase
    end

    // Mispredict repair takes priority over a same-cycle speculative shift.
    always_comb begin
        valid_d = in_pred_valid;
        pred_d  = 1'b0;
        pghr_d  = '0;
        ghr_d   = ghr_q;
        if (in_pred_valid) begin
            pred_d = lookup_pred;
            pghr_d = ghr_q;
            ghr_d  = GHR_W'({ghr_q, lookup_pred});
        end
        if (in_upd_valid && in_upd_mispredict) begin
            ghr_d = GHR_W'({in_upd_ghr, in_upd_taken});
        end
    end

    always_ff @(posedge in_Clk or posedge in_Rst) begin
        if (in_Rst) begin
            ghr_q   <= '0;
            pghr_q  <= '0;
            valid_q <= 1'b0;
            pred_q  <= 1'b0;
        end else begin
            ghr_q   <= ghr_d;
            pghr_q  <= pghr_d;
            valid_q <= valid_d;
            pred_q  <= pred_d;
        end
    end

    assign out_pred_valid = valid_q;
    assign out_prediction = pred_q;
    assign out_pred_ghr   = pghr_q;

endmodule

// File: tb/tb_tournament_predictor.sv
// Directed bench: tournament, bimodal-only and gshare-only builds share one
// stimulus stream; expected values are hand-derived counter/history traces.
module tb_tournament_predictor;

    logic       clk;
    logic       rst;
    logic       pred_valid;
    logic [8:0] pred_pc;
    logic       upd_valid;
    logic [8:0] upd_pc;
    logic [5:0] upd_ghr;
    logic       upd_taken;
    logic       upd_mis;
    logic [2:0] ov;
    logic [2:0] op;
    logic [5:0] og0, og1, og2;

    int errors = 0;
    int checks = 0;

    tournament_predictor #(.MODE(0)) dut_m0 (
        .in_Clk(clk), .in_Rst(rst),
        .in_pred_valid(pred_valid), .in_pred_PC(pred_pc),
        .out_pred_valid(ov[0]), .out_prediction(op[0]), .out_pred_ghr(og0),
        .in_upd_valid(upd_valid), .in_upd_PC(upd_pc), .in_upd_ghr(upd_ghr),
        .in_upd_taken(upd_taken), .in_upd_mispredict(upd_mis)
    );

    tournament_predictor #(.MODE(1)) dut_m1 (
        .in_Clk(clk), .in_Rst(rst),
        .in_pred_valid(pred_valid), .in_pred_PC(pred_pc),
        .out_pred_valid(ov[1]), .out_prediction(op[1]), .out_pred_ghr(og1),
        .in_upd_valid(upd_valid), .in_upd_PC(upd_pc), .in_upd_ghr(upd_ghr),
        .in_upd_taken(upd_taken), .in_upd_mispredict(upd_mis)
    );

    tournament_predictor #(.MODE(2)) dut_m2 (
        .in_Clk(clk), .in_Rst(rst),
        .in_pred_valid(pred_valid), .in_pred_PC(pred_pc),
        .out_pred_valid(ov[2]), .out_prediction(op[2]), .out_pred_ghr(og2),
        .in_upd_valid(upd_valid), .in_upd_PC(upd_pc), .in_upd_ghr(upd_ghr),
        .in_upd_taken(upd_taken), .in_upd_mispredict(upd_mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle();
        pred_valid = 1'b0;
        pred_pc    = '0;
        upd_valid  = 1'b0;
        upd_pc     = '0;
        upd_ghr    = '0;
        upd_taken  = 1'b0;
        upd_mis    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic lookup(input logic [8:0] pc);
        pred_valid = 1'b1;
        pred_pc    = pc;
        tick();
        idle();
    endtask

    task automatic update(input logic [8:0] pc, input logic [5:0] g, input logic t);
        upd_valid = 1'b1;
        upd_pc    = pc;
        upd_ghr   = g;
        upd_taken = t;
        tick();
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset behaviour, including an asynchronous assert mid-lookup
        idle();
        rst = 1'b1;
        tick();
        check("rst_valid", int'(ov), 0);
        check("rst_pred", int'(op), 0);
        check("rst_ghr", int'(og0), 0);
        rst = 1'b0;
        lookup(9'h005);
        check("first_valid", int'(ov[0]), 1);
        check("first_pred", int'(op), 0);
        pred_valid = 1'b1;
        pred_pc    = 9'h005;
        tick();
        check("inflight_valid", int'(ov), 7);
        rst = 1'b1;
        #1;
        check("async_valid", int'(ov), 0);
        check("async_pred", int'(op), 0);
        check("async_ghr", int'(og1), 0);
        idle();
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_idle", int'(ov), 0);
        lookup(9'h005);
        check("post_rst_valid", int'(ov), 7);
        check("post_rst_pred", int'(op[0]), 0);
        check("post_rst_ghr", int'(og0), 0);
        tick();
        check("valid_drops", int'(ov), 0);

        // Saturation at both ends of the counter range
        do_reset();
        repeat (4) update(9'h005, 6'd0, 1'b1);
        check("bim5_max", int'(dut_m1.u_bim.cnt_q[5]), 3);
        lookup(9'h005);
        check("sat_hi_m1", int'(op[1]), 1);
        check("sat_hi_m0", int'(op[0]), 1);
        check("sat_hi_m2", int'(op[2]), 1);
        check("sat_hi_ghr", int'(og1), 0);
        repeat (5) update(9'h005, 6'd0, 1'b0);
        check("bim5_min", int'(dut_m1.u_bim.cnt_q[5]), 0);
        lookup(9'h005);
        check("sat_lo_m1", int'(op[1]), 0);
        check("sat_lo_m0", int'(op[0]), 0);
        check("sat_lo_ghr", int'(og1), 1);
        repeat (2) update(9'h005, 6'd0, 1'b1);
        lookup(9'h005);
        check("recover_m1", int'(op[1]), 1);
        check("recover_m0", int'(op[0]), 1);
        check("recover_m2", int'(op[2]), 0);
        check("recover_ghr", int'(og2), 2);

        // Chooser training, agreement hold, and decrement back to bimodal
        do_reset();
        update(9'h006, 6'd1, 1'b1);
        update(9'h006, 6'd0, 1'b1);
        update(9'h007, 6'd1, 1'b1);
        update(9'h007, 6'd2, 1'b0);
        check("cho7_m0", int'(dut_m0.u_cho.cnt_q[7]), 3);
        check("cho7_m1", int'(dut_m1.u_cho.cnt_q[7]), 1);
        check("cho7_m2", int'(dut_m2.u_cho.cnt_q[7]), 1);
        lookup(9'h007);
        check("cho_sel_gsh", int'(op[0]), 1);
        check("cho_bim_only", int'(op[1]), 0);
        update(9'h007, 6'd2, 1'b0);
        check("cho7_agree", int'(dut_m0.u_cho.cnt_q[7]), 3);
        update(9'h007, 6'd1, 1'b0);
        lookup(9'h007);
        check("cho_still_gsh", int'(op[0]), 1);
        check("cho_ghr1", int'(og0), 1);
        update(9'h004, 6'd0, 1'b1);
        update(9'h007, 6'd0, 1'b0);
        lookup(9'h007);
        check("cho_back_bim", int'(op[0]), 0);
        check("cho_ghr3", int'(og0), 3);
        check("cho7_m1_end", int'(dut_m1.u_cho.cnt_q[7]), 1);
        check("cho7_m2_end", int'(dut_m2.u_cho.cnt_q[7]), 1);

        // History shift, repair over a same-cycle lookup, ignored mispredict
        do_reset();
        update(9'h009, 6'd0, 1'b1);
        lookup(9'h009);
        check("ghr_shift0", int'(og1), 0);
        check("ghr_pred_m1", int'(op[1]), 1);
        lookup(9'h009);
        check("ghr_shift1", int'(og1), 1);
        lookup(9'h009);
        check("ghr_shift3", int'(og1), 3);
        check("ghr_pred_m0", int'(op[0]), 1);
        pred_valid = 1'b1;
        pred_pc    = 9'h009;
        upd_valid  = 1'b1;
        upd_pc     = 9'h000;
        upd_ghr    = 6'b000001;
        upd_taken  = 1'b0;
        upd_mis    = 1'b1;
        tick();
        idle();
        check("ghr_pre_repair", int'(og1), 7);
        lookup(9'h009);
        check("ghr_repair_m1", int'(og1), 2);
        check("ghr_repair_m0", int'(og0), 2);
        check("ghr_repair_m2", int'(og2), 2);
        pred_valid = 1'b1;
        pred_pc    = 9'h009;
        upd_mis    = 1'b1;
        tick();
        idle();
        check("mis_no_valid", int'(og1), 5);
        lookup(9'h009);
        check("mis_no_valid2", int'(og1), 11);

        // Lookup and update of the same entry in one cycle
        do_reset();
        pred_valid = 1'b1;
        pred_pc    = 9'h003;
        upd_valid  = 1'b1;
        upd_pc     = 9'h003;
        upd_ghr    = 6'd0;
        upd_taken  = 1'b1;
        tick();
        idle();
        check("rbw_old", int'(op), 0);
        check("rbw_bim3", int'(dut_m1.u_bim.cnt_q[3]), 2);
        lookup(9'h003);
        check("rbw_new", int'(op), 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tournament_predictor.md
TOURNAMENT_PREDICTOR -- requirements
Module: tournament_predictor

Interface
REQ-001 SHALL have parameter PC_W, default 9, width of branch PC inputs.
REQ-002 SHALL have parameter IDX_W, default 6, log2 of entries per table (2^IDX_W entries), IDX_W <= PC_W.
REQ-003 SHALL have parameter GHR_W, default 6, global history length, 1 <= GHR_W <= IDX_W.
REQ-004 SHALL have parameter CNT_W, default 2, saturating counter width, CNT_W >= 2.
REQ-005 SHALL have parameter MODE, default 0: 0 = tournament, 1 = bimodal only, 2 = gshare only.
REQ-006 SHALL have ports: in_Clk input 1, the single clock; in_Rst input 1, asynchronous active-high reset.
REQ-007 SHALL have ports: in_pred_valid input 1, lookup request; in_pred_PC input PC_W, lookup PC.
REQ-008 SHALL have ports: out_pred_valid output 1; out_prediction output 1 (1 = taken); out_pred_ghr output GHR_W, history snapshot used for the lookup.
REQ-009 SHALL have ports: in_upd_valid input 1; in_upd_PC input PC_W; in_upd_ghr input GHR_W, returned snapshot; in_upd_taken input 1, resolved outcome; in_upd_mispredict input 1.

Function
REQ-010 SHALL hold three tables of 2^IDX_W CNT_W-bit counters: BIM (index PC[IDX_W-1:0]), GSH (index PC[IDX_W-1:0] XOR zero-extended GHR), CHO (index PC[IDX_W-1:0]).
REQ-011 SHALL derive a table prediction as the counter MSB; CHO MSB = 1 selects GSH, 0 selects BIM; MODE 1/2 ignores CHO.
REQ-012 SHALL register lookups with 1-cycle latency: in_pred_valid at edge N gives out_pred_valid = 1 with out_prediction and out_pred_ghr (pre-shift GHR) during cycle N+1; out_pred_valid = 0 otherwise.
REQ-013 SHALL speculatively shift the GHR on each lookup: GHR <= {GHR[GHR_W-2:0], predicted bit}.
REQ-014 SHALL, on in_upd_valid, recompute BIM/GSH predictions at the update indices using in_upd_ghr, then saturate-update BIM and GSH: taken increments (hold at 2^CNT_W-1), not-taken decrements (hold at 0).
REQ-015 SHALL update CHO only when the BIM and GSH predictions disagree: increment if GSH was correct, decrement if BIM was correct, saturating; CHO is never written in MODE 1/2.
REQ-016 SHALL, on in_upd_valid with in_upd_mispredict = 1, repair GHR <= {in_upd_ghr[GHR_W-2:0], in_upd_taken}, overriding a same-cycle speculative shift.
REQ-017 SHALL use read-before-write: a lookup and update to the same entry in one cycle returns the pre-update counter.
REQ-018 SHALL ignore in_upd_mispredict when in_upd_valid = 0.

Reset
REQ-019 SHALL, while in_Rst = 1, immediately force out_pred_valid = 0, out_prediction = 0, out_pred_ghr = 0, GHR = 0.
REQ-020 SHALL reset all BIM/GSH counters to weakly-not-taken (2^(CNT_W-1)-1) and all CHO counters to weakly-bimodal (same value).
REQ-021 SHALL discard any lookup or update in flight when reset asserts mid-operation; first valid output is one cycle after the first post-reset lookup.

Structure
REQ-022 SHALL place MODE encodings, the weak-not-taken reset value function, and saturating inc/dec functions in shared package bpu_pkg.
REQ-023 SHALL implement each table as sub-module sat_counter_table (parametrised IDX_W, CNT_W; one read port, one read-modify-write update port), instantiated three times.

Verification
REQ-024 SHALL cover reset: assert in_Rst mid-lookup -> outputs 0 immediately; first lookup after release, PC=0x05 -> out_prediction = 0, out_pred_ghr = 0.
REQ-025 SHALL cover saturation: 4 taken updates PC=0x05, ghr=0 -> BIM[5] = 3; 5 not-taken -> BIM[5] = 0, no wrap.
REQ-026 SHALL cover chooser: pattern where GSH correct and BIM wrong twice at PC=0x07 -> CHO[7] = 3, lookups select GSH; agreeing updates leave CHO unchanged.
REQ-027 SHALL cover GHR repair: three taken-predicted lookups (GHR = 0b000111), update with mispredict, in_upd_ghr = 0b000001, taken = 0 -> GHR = 0b000010 next cycle, despite a same-cycle lookup.
REQ-028 SHALL cover read-before-write: lookup and update same entry same cycle -> lookup returns old counter MSB.
REQ-029 SHALL cover MODE = 1 and MODE = 2 builds: prediction equals BIM resp. GSH MSB; CHO never changes.
